axi_ram_sim_param: RTL and testbench

Parametrised AXI4 slave memory model for simulation: the successor to our fixed-width simulation RAM. It stores a configurable number of bus-width words behind a configurable base address. It implements FIXED, INCR and WRAP bursts with standard AXI byte-lane placement for narrow and unaligned transfers, returns SLVERR for illegal or out-of-range accesses, and adds a programmable first-beat read latency. It sits at the memory end of the AXI proxy test benches and needs no address pre-shifting by the master.

---
 rtl/axi_ram_sim_param.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_axi_ram_sim_param.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_sim_param.sv
// axi_ram_sim_param
// Parametrised AXI4 slave memory model for simulation.
//
// The memory holds MEM_WORDS words of DATA_WIDTH bits. Word 0 sits at byte
// address BASE_ADDR. FIXED, INCR and WRAP bursts are supported, and narrow or
// unaligned transfers are handled by the AXI byte-lane rules. Illegal or
// out-of-range beats return SLVERR. An illegal burst writes nothing and reads
// back zeros, but it still runs through all of its beats. The first read beat
// is delayed by a programmable latency.
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   s_axi_aw*           : write address channel (lock/cache/prot ignored)
//   s_axi_w*            : write data channel (wlast ignored, awlen counts beats)
//   s_axi_b*            : write response channel
//   s_axi_ar*           : read address channel (lock/cache/prot ignored)
//   s_axi_r*            : read data channel
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an AW handshake
//   W_DATA | wready high, accepting awlen+1 beats
//   W_RESP | bvalid high, holding bid/bresp until bready
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an AR handshake
//   R_WAIT | first-beat latency countdown
//   R_DATA | rvalid high, one beat per rready cycle until rlast
module axi_ram_sim_param #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int                    ID_WIDTH     = 8,
  parameter int                    MEM_WORDS    = 262144,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    READ_LATENCY = 1,
  parameter string                 INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,

  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,

  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,

  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,

  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int                  LG       = $clog2(STRB_WIDTH);
  localparam int                  IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] WORDS_A  = (ADDR_WIDTH+1)'(MEM_WORDS);
  localparam logic [2:0]          MAX_SIZE = 3'(LG);
  localparam logic [3:0]          LAT_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [1:0]          RESP_OK  = 2'b00;
  localparam logic [1:0]          RESP_ERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
  end

  function automatic logic [ADDR_WIDTH-1:0] size_bytes(input logic [2:0] size);
    return {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
  endfunction

  function automatic logic burst_legal(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [2:0]            size,
                                       input logic [1:0]            burst,
                                       input logic [7:0]            len);
    logic ok;
    ok = 1'b1;
    if (size > MAX_SIZE) ok = 1'b0;
    if (burst == 2'b11) ok = 1'b0;
    if (burst == 2'b10) begin
      if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ok = 1'b0;
      if ((addr & (size_bytes(size) - 1'b1)) != '0) ok = 1'b0;
    end
    return ok;
  endfunction

  // Next beat address. For an illegal burst the result is never used to
  // touch memory, so it does not matter what it is.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst,
                                                      input logic [7:0]            len);
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0] nxt;
    incr  = size_bytes(size);
    wmask = ((ADDR_WIDTH'(len) + 1'b1) << size) - 1'b1;
    case (burst)
      2'b00:   nxt = addr;
      2'b10:   nxt = (addr & ~wmask) | ((addr + incr) & wmask);
      default: nxt = (addr & ~(incr - 1'b1)) + incr;
    endcase
    return nxt;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offs;
    offs = (addr - BASE_ADDR) >> LG;
    return (addr >= BASE_ADDR) && ({1'b0, offs} < WORDS_A);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offs;
    offs = (addr - BASE_ADDR) >> LG;
    return offs[IDX_W-1:0];
  endfunction

  // ---------------------------------------------------------------- write
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic                  w_legal;
  logic                  w_err;
  logic                  w_fire;
  logic                  w_beat_ok;
  logic [IDX_W-1:0]      w_idx;

  assign w_fire    = (w_state == W_DATA) && s_axi_wvalid;
  assign w_beat_ok = w_legal && in_range(w_addr);
  assign w_idx     = word_index(w_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OK;
      s_axi_bid     <= '0;
      w_addr        <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_legal       <= 1'b0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awready && s_axi_awvalid) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            s_axi_bid     <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_size        <= s_axi_awsize;
            w_burst       <= s_axi_awburst;
            w_len         <= s_axi_awlen;
            w_cnt         <= s_axi_awlen;
            w_legal       <= burst_legal(s_axi_awaddr, s_axi_awsize, s_axi_awburst, s_axi_awlen);
            w_err         <= 1'b0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_size, w_burst, w_len);
            w_cnt  <= w_cnt - 8'd1;
            if (!w_beat_ok) w_err <= 1'b1;
            if (w_cnt == 8'd0) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err || !w_beat_ok) ? RESP_ERR : RESP_OK;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory write port. It has no reset, so the contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && w_beat_ok) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic                  r_legal;
  logic [3:0]            r_timer;
  logic                  r_load;
  logic                  r_beat_ok;
  logic [IDX_W-1:0]      r_idx;

  assign r_beat_ok = r_legal && in_range(r_addr);
  assign r_idx     = word_index(r_addr);
  // A new beat goes onto the bus when the latency expires, or when the
  // current non-final beat is accepted.
  assign r_load    = ((r_state == R_WAIT) && (r_timer == 4'd0)) ||
                     ((r_state == R_DATA) && s_axi_rready && !s_axi_rlast);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OK;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      r_addr        <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_legal       <= 1'b0;
      r_timer       <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arready && s_axi_arvalid) begin
            s_axi_arready <= 1'b0;
            s_axi_rid     <= s_axi_arid;
            r_addr        <= s_axi_araddr;
            r_size        <= s_axi_arsize;
            r_burst       <= s_axi_arburst;
            r_len         <= s_axi_arlen;
            r_cnt         <= s_axi_arlen;
            r_legal       <= burst_legal(s_axi_araddr, s_axi_arsize, s_axi_arburst, s_axi_arlen);
            r_timer       <= LAT_LOAD;
            r_state       <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_timer == 4'd0) r_state <= R_DATA;
          else                 r_timer <= r_timer - 4'd1;
        end
        R_DATA: begin
          if (s_axi_rready && s_axi_rlast) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase

      if (r_load) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= r_beat_ok ? mem[r_idx] : '0;
        s_axi_rresp  <= r_beat_ok ? RESP_OK : RESP_ERR;
        s_axi_rlast  <= (r_cnt == 8'd0);
        r_addr       <= next_addr(r_addr, r_size, r_burst, r_len);
        r_cnt        <= r_cnt - 8'd1;
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = &{1'b0, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_wlast};

endmodule

// File: tb/tb_axi_ram_sim_param.sv
module tb_axi_ram_sim_param;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 256;
  localparam int          LAT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [WORDS];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  always #5 clk = ~clk;

  axi_ram_sim_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .MEM_WORDS(WORDS),
    .BASE_ADDR(BASE), .READ_LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  // ------------------------------------------------------ reference model
  function automatic logic [31:0] m_beat_addr(input logic [31:0] a, input int sz,
                                              input int b, input int len, input int i);
    longint unsigned av, n, win, wst;
    av = a;
    n  = 64'd1 << sz;
    if (b == 0) return a;
    if (b == 1) return (i == 0) ? a : 32'((av / n) * n + longint'(i) * n);
    win = longint'(len + 1) * n;
    wst = (av / win) * win;
    return 32'(wst + ((av - wst) + longint'(i) * n) % win);
  endfunction

  function automatic bit m_legal(input logic [31:0] a, input int sz, input int b, input int len);
    if (sz > 2) return 0;
    if (b == 3) return 0;
    if (b == 2 && !(len inside {1, 3, 7, 15})) return 0;
    if (b == 2 && (a % (32'd1 << sz)) != 0) return 0;
    return 1;
  endfunction

  function automatic bit m_in_range(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) / 4 < WORDS);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // -------------------------------------------------------------- drivers
  task automatic write_burst(input string name, input logic [31:0] a, input int len,
                             input int sz, input int b, input logic [7:0] id, input int bdelay);
    logic [1:0]  exp_resp;
    logic [31:0] ba;
    bit          lg, ok;
    int          t;
    exp_resp = 2'b00;
    lg = m_legal(a, sz, b, len);
    for (int i = 0; i <= len; i++) begin
      ba = m_beat_addr(a, sz, b, len, i);
      ok = lg && m_in_range(ba);
      if (!ok) exp_resp = 2'b10;
      if (ok) for (int j = 0; j < 4; j++)
        if (ws[i][j]) ref_mem[m_idx(ba)][j*8 +: 8] = wd[i][j*8 +: 8];
    end

    awid = id; awaddr = a; awlen = 8'(len); awsize = 3'(sz); awburst = 2'(b); awvalid = 1'b1;
    t = 0;
    while (awready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    tests++;
    if (t >= 50) begin
      fails++; $display("FAIL %s aw_timeout: awready=%b required 1", name, awready);
      awvalid = 1'b0; return;
    end
    @(posedge clk); #1; awvalid = 1'b0;

    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len); wvalid = 1'b1;
      t = 0;
      while (wready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) begin
        tests++; fails++; $display("FAIL %s w_timeout beat %0d: wready=%b required 1", name, i, wready);
        wvalid = 1'b0; return;
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;

    t = 0;
    while (bvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    tests++;
    if (t >= 50) begin
      fails++; $display("FAIL %s b_timeout: bvalid=%b required 1", name, bvalid); return;
    end
    for (int d = 0; d < bdelay; d++) begin
      tests++;
      if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0) begin
        fails++;
        $display("FAIL %s b_hold cycle %0d: bvalid=%b bresp=%b awready=%b required 1/%b/0",
                 name, d, bvalid, bresp, awready, exp_resp);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (bresp !== exp_resp || bid !== id) begin
      fails++; $display("FAIL %s bresp/bid: got %b/%h required %b/%h", name, bresp, bid, exp_resp, id);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    tests++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      fails++; $display("FAIL %s b_done: bvalid=%b awready=%b required 0/1", name, bvalid, awready);
    end
  endtask

  // mode 0: rready held high; mode 1: rready toggles every cycle.
  task automatic read_burst(input string name, input logic [31:0] a, input int len,
                            input int sz, input int b, input logic [7:0] id,
                            input int mode, input bit chk_lat);
    logic [31:0] e_data [256];
    logic [1:0]  e_resp [256];
    logic [31:0] ba, h_data;
    logic [1:0]  h_resp;
    logic        h_last;
    bit          lg, ok, held, done, lat_done;
    int          t, beats, cycles, lat;
    lg = m_legal(a, sz, b, len);
    for (int i = 0; i <= len; i++) begin
      ba = m_beat_addr(a, sz, b, len, i);
      ok = lg && m_in_range(ba);
      e_data[i] = ok ? ref_mem[m_idx(ba)] : 32'd0;
      e_resp[i] = ok ? 2'b00 : 2'b10;
    end

    arid = id; araddr = a; arlen = 8'(len); arsize = 3'(sz); arburst = 2'(b); arvalid = 1'b1;
    t = 0;
    while (arready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    tests++;
    if (t >= 50) begin
      fails++; $display("FAIL %s ar_timeout: arready=%b required 1", name, arready);
      arvalid = 1'b0; return;
    end
    @(posedge clk); #1; arvalid = 1'b0;

    rready = 1'b1;
    beats = 0; cycles = 0; lat = 0; held = 0; done = 0; lat_done = 0;
    h_data = '0; h_resp = '0; h_last = 1'b0;
    while (!done && cycles < 2000 + 4 * len) begin
      if (held) begin
        tests++;
        if (rvalid !== 1'b1 || rdata !== h_data || rresp !== h_resp || rlast !== h_last) begin
          fails++;
          $display("FAIL %s hold beat %0d: v=%b d=%h r=%b l=%b required 1/%h/%b/%b",
                   name, beats, rvalid, rdata, rresp, rlast, h_data, h_resp, h_last);
        end
        held = 0;
      end
      if (rvalid === 1'b1) begin
        if (chk_lat && !lat_done) begin
          tests++;
          if (lat != LAT) begin
            fails++; $display("FAIL %s latency: got %0d required %0d", name, lat, LAT);
          end
        end
        lat_done = 1;
        if (rready) begin
          tests++;
          if (beats > len) begin
            fails++; $display("FAIL %s extra beat %0d: got d=%h required none", name, beats, rdata);
          end else if (rdata !== e_data[beats] || rresp !== e_resp[beats] ||
                       rlast !== (beats == len) || rid !== id) begin
            fails++;
            $display("FAIL %s beat %0d: d=%h r=%b l=%b id=%h required %h/%b/%b/%h",
                     name, beats, rdata, rresp, rlast, rid, e_data[beats], e_resp[beats],
                     (beats == len), id);
          end
          if (rlast === 1'b1) done = 1;
          beats++;
        end else begin
          held = 1; h_data = rdata; h_resp = rresp; h_last = rlast;
        end
      end
      @(posedge clk); #1;
      cycles++;
      if (!lat_done) lat++;
      if (mode == 1) rready = ~rready;
    end
    rready = 1'b0;
    tests++;
    if (!done || beats != len + 1 || rvalid !== 1'b0) begin
      fails++;
      $display("FAIL %s beat_count: got %0d beats rvalid_after=%b required %0d beats rvalid_after=0",
               name, beats, rvalid, len + 1);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 ||
        bresp !== 2'b0 || rresp !== 2'b0 || bid !== 8'h0 || rid !== 8'h0 || rdata !== 32'h0) begin
      fails++; $display("FAIL reset_in: outputs not zero, aw=%b ar=%b rd=%h", awready, arready, rdata);
    end
    rst = 1'b0;
    tests++;
    if (awready !== 1'b0 || arready !== 1'b0 || rvalid !== 1'b0 || bvalid !== 1'b0) begin
      fails++; $display("FAIL reset_first_cycle: aw=%b ar=%b required 0/0", awready, arready);
    end
    @(posedge clk); #1;
    tests++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      fails++; $display("FAIL reset_ready_rise: aw=%b ar=%b required 1/1", awready, arready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11 * (i + 1); ws[i] = 4'hF; end
    write_burst("basic_wr", BASE, 3, 2, 1, 8'h5A, 0);
    read_burst("basic_rd", BASE, 3, 2, 1, 8'hA5, 0, 1);
  endtask

  task automatic test_narrow();
    wd[0] = 32'h00AB_0000; ws[0] = 4'h4;
    wd[1] = 32'hCD00_0000; ws[1] = 4'h8;
    write_burst("narrow_wr", BASE + 32'h12, 1, 0, 1, 8'h01, 0);
    tests++;
    if (ref_mem[4] !== 32'hCDAB_0000) begin
      fails++; $display("FAIL narrow_model: got %h required cdab0000", ref_mem[4]);
    end
    read_burst("narrow_rd", BASE + 32'h10, 0, 2, 1, 8'h02, 0, 1);
  endtask

  task automatic test_wrap();
    read_burst("wrap_rd", BASE + 32'h8, 3, 2, 2, 8'h03, 0, 1);
    read_burst("wrap_bad_len", BASE + 32'h8, 2, 2, 2, 8'h04, 0, 1);
    read_burst("wrap_unaligned", BASE + 32'h2, 3, 2, 2, 8'h05, 0, 0);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    read_burst("burst_rsvd", BASE, 0, 2, 3, 8'h06, 0, 0);
    write_burst("size_too_big", BASE, 0, 3, 1, 8'h07, 0);
    read_burst("size_check", BASE, 0, 2, 1, 8'h08, 0, 0);
  endtask

  task automatic test_out_of_range();
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    write_burst("oor_below", 32'h0, 0, 2, 1, 8'h09, 0);
    read_burst("oor_word0", BASE, 0, 2, 1, 8'h0A, 0, 0);
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    write_burst("last_word_wr", BASE + 32'h3FC, 0, 2, 1, 8'h0B, 0);
    read_burst("last_word_rd", BASE + 32'h3FC, 1, 2, 1, 8'h0C, 0, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst("bp_wr", BASE + 32'h40, 7, 2, 1, 8'h0D, 5);
    read_burst("bp_rd", BASE + 32'h40, 7, 2, 1, 8'h0E, 1, 1);
  endtask

  task automatic test_reset_mid_read();
    int t;
    araddr = BASE + 32'h40; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arid = 8'h0F;
    arvalid = 1'b1;
    t = 0;
    while (arready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1; arvalid = 1'b0;
    rready = 1'b1;
    t = 0;
    while (rvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    tests++;
    if (t >= 50) begin
      fails++; $display("FAIL rst_mid rvalid_timeout: rvalid=%b required 1", rvalid);
    end
    @(posedge clk); #1;
    rst = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || rlast !== 1'b0) begin
      fails++; $display("FAIL rst_mid_off: rvalid=%b arready=%b required 0/0", rvalid, arready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (arready !== 1'b1 || awready !== 1'b1 || rvalid !== 1'b0) begin
      fails++; $display("FAIL rst_mid_release: arready=%b awready=%b required 1/1", arready, awready);
    end
    read_burst("rst_mid_intact", BASE + 32'h40, 7, 2, 1, 8'h10, 0, 1);
    read_burst("rst_mid_word0", BASE, 3, 2, 1, 8'h11, 0, 0);
  endtask

  task automatic test_long_burst();
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
    write_burst("long_wr", BASE, 255, 2, 1, 8'h12, 0);
    read_burst("long_rd", BASE, 255, 2, 1, 8'h13, 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int len, sz, b, sel;
    for (int n = 0; n < 30; n++) begin
      a   = BASE - 32'd16 + 32'($urandom_range(0, WORDS * 4 + 32));
      sel = $urandom_range(0, 9);
      b   = (sel < 4) ? 1 : (sel < 7) ? 2 : (sel < 9) ? 0 : 3;
      sz  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      len = (b == 2 && $urandom_range(0, 3) != 0) ? (2 ** $urandom_range(1, 3)) - 1
                                                   : $urandom_range(0, 7);
      if (b == 2 && sz <= 2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      write_burst("rand_wr", a, len, sz, b, 8'($urandom), $urandom_range(0, 2));
      read_burst("rand_rd_same", a, len, sz, b, 8'($urandom), $urandom_range(0, 1), 1);
      a = BASE + 32'($urandom_range(0, WORDS - 8) * 4);
      read_burst("rand_rd_incr", a, $urandom_range(0, 7), 2, 1, 8'($urandom), $urandom_range(0, 1), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_narrow();
    test_wrap();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_read();
    test_long_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
